noc_credit_link: RTL and testbench
==================================

Name: noc_credit_link

Overview:
- Parametrised multi-lane, credit-based router-to-router link: NUM_LANES independent lanes, each with NUM_PIPELINE register stages on the forward flit path and NUM_PIPELINE stages on the reverse credit path.
- Tracks available downstream buffer credits per lane at the upstream side and raises sticky protocol-error flags.
- Sits between a router output port and the neighbouring router input port; it is the successor of the single-lane, wire-only link in the router wrapper.

Parameters:
- NUM_LANES, 4, number of independent links (one per router mesh port).
- FLIT_WIDTH, 32, flit data width.
- DEST_WIDTH, 6, destination field width.
- NUM_PIPELINE, 0, register stages on each direction; 0 gives a pure combinational pass-through.
- FLIT_BUFFER_DEPTH, 4, downstream input-buffer depth; this is the initial credit value.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived).

Ports:
- clk_noc  input  1  NoC clock.
- rst_n  input  1  synchronous active-low reset.
- data_in  input  [0:NUM_LANES-1][FLIT_WIDTH-1:0]  upstream flit data.
- dest_in  input  [0:NUM_LANES-1][DEST_WIDTH-1:0]  upstream destination.
- is_tail_in  input  [0:NUM_LANES-1]  upstream tail marker.
- send_in  input  [0:NUM_LANES-1]  upstream flit valid.
- credit_out  output  [0:NUM_LANES-1]  credit returned to upstream (delayed credit_in).
- data_out  output  [0:NUM_LANES-1][FLIT_WIDTH-1:0]  delayed flit to downstream.
- dest_out  output  [0:NUM_LANES-1][DEST_WIDTH-1:0]  delayed destination.
- is_tail_out  output  [0:NUM_LANES-1]  delayed tail marker.
- send_out  output  [0:NUM_LANES-1]  delayed flit valid.
- credit_in  input  [0:NUM_LANES-1]  credit from downstream.
- credit_count  output  [0:NUM_LANES-1][CREDIT_WIDTH-1:0]  credits currently available to upstream.
- link_idle  output  [0:NUM_LANES-1]  lane drained: full credits and no flit or credit in flight.
- err_underflow  output  [0:NUM_LANES-1]  sticky: send without a credit.
- err_overflow  output  [0:NUM_LANES-1]  sticky: credit beyond FLIT_BUFFER_DEPTH.

Behaviour:
- One clock, clk_noc; reset is synchronous and active-low (rst_n sampled on the rising edge of clk_noc). All lanes are identical and independent.
- Forward path:
  - send_out/data_out/dest_out/is_tail_out equal the inputs delayed exactly NUM_PIPELINE cycles.
  - Payload registers load every cycle; no enable.
- Reverse path: credit_out equals credit_in delayed exactly NUM_PIPELINE cycles.
- Credit counter (upstream view):
  - Reset value FLIT_BUFFER_DEPTH.
  - Per cycle: send_in only gives -1; credit_out only gives +1; both or neither leaves the count unchanged.
  - Underflow: send_in=1, credit_out=0, count==0 → count stays 0, err_underflow set.
  - Overflow: credit_out=1, send_in=0, count==FLIT_BUFFER_DEPTH → count stays at DEPTH, err_overflow set.
  - Error flags are sticky until reset.
- link_idle = (count==FLIT_BUFFER_DEPTH) && no send bit in any forward stage && no credit bit in any reverse stage. With NUM_PIPELINE=0 this reduces to count==DEPTH.
- Reset (rst_n=0 at clk edge):
  - All pipeline valid bits (send, credit) cleared; payload stage registers cleared to 0.
  - Counts set to DEPTH, error flags cleared, link_idle=1 from the first post-reset cycle.
  - Reset mid-packet discards all in-flight flits and credits; no partial-state retention.
- NUM_PIPELINE=0: combinational outputs (NUM_PIPELINE=0 pure pass-through); the counter and flags remain registered.

Optional Feature:
- Macro NOC_LINK_STATS_EN.
- Defined: adds ports flit_count [0:NUM_LANES-1][31:0] and pkt_count [0:NUM_LANES-1][31:0], plus input stats_clear (1 bit).
  - flit_count increments on send_in; pkt_count increments on send_in && is_tail_in.
  - Both counters saturate at 32'hFFFF_FFFF, clear on reset or stats_clear, and stats_clear has priority over increment.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- NUM_PIPELINE=2, lane 1: send_in pulse with data 32'hDEADBEEF, is_tail=1 at cycle 10 → send_out/data_out/is_tail_out seen at cycle 12 only; credit_count[1] goes 4→3 at cycle 11.
- DEPTH=4: send 4 flits back-to-back with no credits → count reaches 0, no error; 5th send → err_underflow[lane]=1, count stays 0; other lanes' flags stay 0.
- Count at 2, send_in and credit_out in the same cycle → count stays 2; then 2 credits with no sends → 4, link_idle=1 once both pipelines are empty; an extra credit → err_overflow=1.
- NUM_PIPELINE=3: credit_in pulse at cycle 20 → credit_out at cycle 23; link_idle=0 during cycles 20-23.
- Assert rst_n=0 with 2 flits in flight → next cycle send_out=0, counts=4, flags=0, link_idle=1; in-flight flits never appear.
- With NOC_LINK_STATS_EN: 3 packets of 4 flits → flit_count=12, pkt_count=3; stats_clear coincident with a send → both counters 0.

Source files
------------

// File: rtl/noc_credit_link.sv
// Multi-lane credit-based NoC link: per-lane forward flit pipeline, reverse credit pipeline,
// upstream credit counter with sticky error flags. Optional per-lane statistics under NOC_LINK_STATS_EN.
module noc_credit_link #(
  parameter int NUM_LANES         = 4,
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int NUM_PIPELINE      = 0,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                    clk_noc,
  input  logic                                    rst_n,
  input  logic [0:NUM_LANES-1][FLIT_WIDTH-1:0]    data_in,
  input  logic [0:NUM_LANES-1][DEST_WIDTH-1:0]    dest_in,
  input  logic [0:NUM_LANES-1]                    is_tail_in,
  input  logic [0:NUM_LANES-1]                    send_in,
  output logic [0:NUM_LANES-1]                    credit_out,
  output logic [0:NUM_LANES-1][FLIT_WIDTH-1:0]    data_out,
  output logic [0:NUM_LANES-1][DEST_WIDTH-1:0]    dest_out,
  output logic [0:NUM_LANES-1]                    is_tail_out,
  output logic [0:NUM_LANES-1]                    send_out,
  input  logic [0:NUM_LANES-1]                    credit_in,
  output logic [0:NUM_LANES-1][CREDIT_WIDTH-1:0]  credit_count,
  output logic [0:NUM_LANES-1]                    link_idle,
  output logic [0:NUM_LANES-1]                    err_underflow,
  output logic [0:NUM_LANES-1]                    err_overflow
`ifdef NOC_LINK_STATS_EN
  ,
  input  logic                                    stats_clear,
  output logic [0:NUM_LANES-1][31:0]              flit_count,
  output logic [0:NUM_LANES-1][31:0]              pkt_count
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C   = CREDIT_WIDTH'(1);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic credit_dly;
    logic fwd_busy;
    logic rev_busy;

    if (NUM_PIPELINE == 0) begin : g_comb
      assign send_out[l]    = send_in[l];
      assign data_out[l]    = data_in[l];
      assign dest_out[l]    = dest_in[l];
      assign is_tail_out[l] = is_tail_in[l];
      assign credit_dly     = credit_in[l];
      assign fwd_busy       = 1'b0;
      assign rev_busy       = 1'b0;
    end else begin : g_pipe
      logic [NUM_PIPELINE-1:0]                 send_q, send_d;
      logic [NUM_PIPELINE-1:0]                 credit_q, credit_d;
      logic [NUM_PIPELINE-1:0]                 tail_q, tail_d;
      logic [NUM_PIPELINE-1:0][FLIT_WIDTH-1:0] data_q, data_d;
      logic [NUM_PIPELINE-1:0][DEST_WIDTH-1:0] dest_q, dest_d;

      // Stage 0 captures the inputs; every later stage shifts from its predecessor.
      always_comb begin
        send_d[0]   = send_in[l];
        credit_d[0] = credit_in[l];
        tail_d[0]   = is_tail_in[l];
        data_d[0]   = data_in[l];
        dest_d[0]   = dest_in[l];
        for (int s = 1; s < NUM_PIPELINE; s++) begin
          send_d[s]   = send_q[s-1];
          credit_d[s] = credit_q[s-1];
          tail_d[s]   = tail_q[s-1];
          data_d[s]   = data_q[s-1];
          dest_d[s]   = dest_q[s-1];
        end
      end

      always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
          send_q   <= '0;
          credit_q <= '0;
          tail_q   <= '0;
          data_q   <= '0;
          dest_q   <= '0;
        end else begin
          send_q   <= send_d;
          credit_q <= credit_d;
          tail_q   <= tail_d;
          data_q   <= data_d;
          dest_q   <= dest_d;
        end
      end

      assign send_out[l]    = send_q[NUM_PIPELINE-1];
      assign data_out[l]    = data_q[NUM_PIPELINE-1];
      assign dest_out[l]    = dest_q[NUM_PIPELINE-1];
      assign is_tail_out[l] = tail_q[NUM_PIPELINE-1];
      assign credit_dly     = credit_q[NUM_PIPELINE-1];
      assign fwd_busy       = |send_q;
      assign rev_busy       = |credit_q;
    end

    assign credit_out[l] = credit_dly;

    logic [CREDIT_WIDTH-1:0] count_q, count_d;
    logic                    uf_q, uf_d;
    logic                    of_q, of_d;

    // The counter sees credits only once they leave the reverse pipeline.
    always_comb begin
      count_d = count_q;
      uf_d    = uf_q;
      of_d    = of_q;
      if (send_in[l] && !credit_dly) begin
        if (count_q == '0) uf_d = 1'b1;
        else               count_d = count_q - ONE_C;
      end else if (credit_dly && !send_in[l]) begin
        if (count_q == DEPTH_C) of_d = 1'b1;
        else                    count_d = count_q + ONE_C;
      end
    end

    always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
        count_q <= DEPTH_C;
        uf_q    <= 1'b0;
        of_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        uf_q    <= uf_d;
        of_q    <= of_d;
      end
    end

    assign credit_count[l]  = count_q;
    assign err_underflow[l] = uf_q;
    assign err_overflow[l]  = of_q;
    assign link_idle[l]     = (count_q == DEPTH_C) && !fwd_busy && !rev_busy;

`ifdef NOC_LINK_STATS_EN
    logic [31:0] flit_cnt_q, flit_cnt_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    // Clear wins over increment; both counters stick at all-ones.
    always_comb begin
      flit_cnt_d = flit_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      if (stats_clear) begin
        flit_cnt_d = '0;
        pkt_cnt_d  = '0;
      end else begin
        if (send_in[l] && (flit_cnt_q != 32'hFFFF_FFFF)) flit_cnt_d = flit_cnt_q + 32'd1;
        if (send_in[l] && is_tail_in[l] && (pkt_cnt_q != 32'hFFFF_FFFF)) pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
    end

    always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
        flit_cnt_q <= '0;
        pkt_cnt_q  <= '0;
      end else begin
        flit_cnt_q <= flit_cnt_d;
        pkt_cnt_q  <= pkt_cnt_d;
      end
    end

    assign flit_count[l] = flit_cnt_q;
    assign pkt_count[l]  = pkt_cnt_q;
`endif
  end

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: pass-through (0), two-stage and three-stage instances,
// table vectors on the pass-through lanes and a flit scoreboard on the two-stage link.
module tb_noc_credit_link;

  localparam int SB_W = 73;
  localparam logic [0:3][2:0] ALL4 = {4{3'd4}};

  logic clk_noc;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [0:3][31:0] data_in0, data_out0, data_in2, data_out2, data_in3, data_out3;
  logic [0:3][5:0]  dest_in0, dest_out0, dest_in2, dest_out2, dest_in3, dest_out3;
  logic [0:3]       tail_in0, tail_out0, tail_in2, tail_out2, tail_in3, tail_out3;
  logic [0:3]       send_in0, send_out0, send_in2, send_out2, send_in3, send_out3;
  logic [0:3]       credit_in0, credit_out0, credit_in2, credit_out2, credit_in3, credit_out3;
  logic [0:3][2:0]  cnt0, cnt2, cnt3;
  logic [0:3]       idle0, idle2, idle3, uf0, uf2, uf3, of0, of2, of3;
`ifdef NOC_LINK_STATS_EN
  logic             stats_clear;
  logic [0:3][31:0] fc0, pc0, fc2, pc2, fc3, pc3;
`endif

  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] sb_got;
  logic [SB_W-1:0] sb_exp;

  typedef struct {
    logic [0:3]      send;
    logic [0:3]      cred;
    logic [0:3][2:0] cnt;
    logic [0:3]      uf;
    logic [0:3]      of;
    logic [0:3]      idle;
  } vec_t;
  vec_t tbl[14];

  noc_credit_link #(.NUM_PIPELINE(0)) dut0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in0), .dest_in(dest_in0),
    .is_tail_in(tail_in0), .send_in(send_in0), .credit_out(credit_out0),
    .data_out(data_out0), .dest_out(dest_out0), .is_tail_out(tail_out0),
    .send_out(send_out0), .credit_in(credit_in0), .credit_count(cnt0),
    .link_idle(idle0), .err_underflow(uf0), .err_overflow(of0)
`ifdef NOC_LINK_STATS_EN
    , .stats_clear(stats_clear), .flit_count(fc0), .pkt_count(pc0)
`endif
  );

  noc_credit_link #(.NUM_PIPELINE(2)) dut2 (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in2), .dest_in(dest_in2),
    .is_tail_in(tail_in2), .send_in(send_in2), .credit_out(credit_out2),
    .data_out(data_out2), .dest_out(dest_out2), .is_tail_out(tail_out2),
    .send_out(send_out2), .credit_in(credit_in2), .credit_count(cnt2),
    .link_idle(idle2), .err_underflow(uf2), .err_overflow(of2)
`ifdef NOC_LINK_STATS_EN
    , .stats_clear(stats_clear), .flit_count(fc2), .pkt_count(pc2)
`endif
  );

  noc_credit_link #(.NUM_PIPELINE(3)) dut3 (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in3), .dest_in(dest_in3),
    .is_tail_in(tail_in3), .send_in(send_in3), .credit_out(credit_out3),
    .data_out(data_out3), .dest_out(dest_out3), .is_tail_out(tail_out3),
    .send_out(send_out3), .credit_in(credit_in3), .credit_count(cnt3),
    .link_idle(idle3), .err_underflow(uf3), .err_overflow(of3)
`ifdef NOC_LINK_STATS_EN
    , .stats_clear(stats_clear), .flit_count(fc3), .pkt_count(pc3)
`endif
  );

  // Clock and cycle counter
  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;
  always @(posedge clk_noc) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_noc);
    #1;
    send_in0 = '0; send_in2 = '0; send_in3 = '0;
    credit_in0 = '0; credit_in2 = '0; credit_in3 = '0;
`ifdef NOC_LINK_STATS_EN
    stats_clear = 1'b0;
`endif
  endtask

  // Drive one flit on the two-stage link; tracked flits must appear exactly two cycles later.
  task automatic drive2(input int lane, input logic [31:0] d, input logic [5:0] dst,
                        input logic tl, input bit track);
    send_in2[lane] = 1'b1;
    data_in2[lane] = d;
    dest_in2[lane] = dst;
    tail_in2[lane] = tl;
    if (track) exp_q.push_back({32'(cyc + 2), 2'(lane), tl, dst, d});
  endtask

  // Scoreboard: every flit leaving the two-stage link must match the head of exp_q
  always @(negedge clk_noc) begin
    for (int l = 0; l < 4; l++) begin
      if (send_out2[l] === 1'b1) begin
        sb_got = {32'(cyc), 2'(l), tail_out2[l], dest_out2[l], data_out2[l]};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_flit: got lane %0d data 0x%0h at cycle %0d, expected no flit", l, data_out2[l], cyc);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_got !== sb_exp) begin
            n_err++;
            $display("FAIL sb_flit: got 0x%0h expected 0x%0h (cycle %0d)", sb_got, sb_exp, cyc);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    data_in0 = '0; dest_in0 = '0; tail_in0 = '0; send_in0 = '0; credit_in0 = '0;
    data_in2 = '0; dest_in2 = '0; tail_in2 = '0; send_in2 = '0; credit_in2 = '0;
    data_in3 = '0; dest_in3 = '0; tail_in3 = '0; send_in3 = '0; credit_in3 = '0;
`ifdef NOC_LINK_STATS_EN
    stats_clear = 1'b0;
`endif

    //            send      cred      counts                          uf        of        idle
    tbl[0]  = '{4'b1111, 4'b0000, {3'd3, 3'd3, 3'd3, 3'd3}, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1100, 4'b0000, {3'd2, 3'd2, 3'd3, 3'd3}, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1000, 4'b0100, {3'd1, 3'd3, 3'd3, 3'd3}, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b1000, {3'd1, 3'd3, 3'd3, 3'd3}, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1000, 4'b0000, {3'd0, 3'd3, 3'd3, 3'd3}, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b1000, 4'b0000, {3'd0, 3'd3, 3'd3, 3'd3}, 4'b1000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0111, {3'd0, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0000, 4'b0111};
    tbl[7]  = '{4'b0000, 4'b0100, {3'd0, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b0111};
    tbl[8]  = '{4'b0000, 4'b1000, {3'd1, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b0111};
    tbl[9]  = '{4'b0010, 4'b0010, {3'd1, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b0111};
    tbl[10] = '{4'b0000, 4'b1000, {3'd2, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b0111};
    tbl[11] = '{4'b0000, 4'b1000, {3'd3, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b0111};
    tbl[12] = '{4'b0000, 4'b1000, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b1000, 4'b0100, 4'b1111};
    tbl[13] = '{4'b0001, 4'b0000, {3'd4, 3'd4, 3'd4, 3'd3}, 4'b1000, 4'b0100, 4'b1110};

    // Reset and post-reset state
    repeat (3) next_cycle();
    rst_n = 1'b1;
    check("rst_cnt0", cnt0, ALL4);
    check("rst_cnt2", cnt2, ALL4);
    check("rst_cnt3", cnt3, ALL4);
    check("rst_idle2", idle2, 4'b1111);
    check("rst_idle3", idle3, 4'b1111);
    check("rst_flags2", {uf2, of2}, 8'h00);
    check("rst_send_out3", send_out3, 4'b0000);
    check("rst_credit_out2", credit_out2, 4'b0000);

    // Table vectors on the pass-through link
    for (int i = 0; i < 14; i++) begin
      send_in0   = tbl[i].send;
      credit_in0 = tbl[i].cred;
      for (int l = 0; l < 4; l++) begin
        data_in0[l] = $urandom;
        dest_in0[l] = 6'($urandom_range(0, 63));
        tail_in0[l] = 1'($urandom_range(0, 1));
      end
      #1;
      check("p0_send_out", send_out0, tbl[i].send);
      check("p0_credit_out", credit_out0, tbl[i].cred);
      check("p0_payload", {data_out0, dest_out0, tail_out0}, {data_in0, dest_in0, tail_in0});
      next_cycle();
      check("p0_count", cnt0, tbl[i].cnt);
      check("p0_underflow", uf0, tbl[i].uf);
      check("p0_overflow", of0, tbl[i].of);
      check("p0_idle", idle0, tbl[i].idle);
    end
    check("p0_lane_isolation", {uf3, of3}, 8'h00);

    // Two-stage latency on lane 1
    drive2(1, 32'hDEADBEEF, 6'd9, 1'b1, 1'b1);
    check("A_cnt_before", cnt2[1], 3'd4);
    next_cycle();
    check("A_cnt_after", cnt2[1], 3'd3);
    check("A_not_early", send_out2, 4'b0000);
    next_cycle();
    next_cycle();
    check("A_not_late", send_out2, 4'b0000);

    // Exhaust lane 2 credits, then one more send
    for (int i = 0; i < 4; i++) begin
      drive2(2, $urandom, 6'(i), (i == 3), 1'b1);
      next_cycle();
    end
    check("B_cnt_empty", cnt2[2], 3'd0);
    check("B_uf_none", uf2, 4'b0000);
    drive2(2, $urandom, 6'd7, 1'b1, 1'b1);
    next_cycle();
    check("B_cnt_stuck", cnt2[2], 3'd0);
    check("B_uf_lane2", uf2, 4'b0010);
    check("B_of_none", of2, 4'b0000);

    // Lane 1: send coinciding with a returned credit, refill, then overflow
    drive2(1, $urandom, 6'd1, 1'b0, 1'b1);
    next_cycle();
    check("C_cnt2", cnt2[1], 3'd2);
    credit_in2[1] = 1'b1;
    next_cycle();
    next_cycle();
    check("C_credit_out", credit_out2, 4'b0100);
    drive2(1, $urandom, 6'd2, 1'b1, 1'b1);
    next_cycle();
    check("C_cnt_both", cnt2[1], 3'd2);
    credit_in2[1] = 1'b1;
    next_cycle();
    credit_in2[1] = 1'b1;
    next_cycle();
    check("C_idle_inflight", idle2, 4'b1001);
    next_cycle();
    next_cycle();
    check("C_cnt_full", cnt2[1], 3'd4);
    check("C_idle_drained", idle2, 4'b1101);
    credit_in2[1] = 1'b1;
    repeat (3) next_cycle();
    check("C_of_lane1", of2, 4'b0100);
    check("C_cnt_clamped", cnt2[1], 3'd4);
    check("C_uf_kept", uf2, 4'b0010);

    // Three-stage link: forward and reverse latency, idle while credit in flight
    send_in3[0] = 1'b1;
    data_in3[0] = 32'hCAFE0003;
    dest_in3[0] = 6'd3;
    tail_in3[0] = 1'b1;
    next_cycle();
    check("D_cnt3", cnt3[0], 3'd3);
    next_cycle();
    check("D_not_early", send_out3, 4'b0000);
    next_cycle();
    check("D_send_out", send_out3, 4'b1000);
    check("D_payload", {data_out3[0], dest_out3[0], tail_out3[0]}, {32'hCAFE0003, 6'd3, 1'b1});
    next_cycle();
    check("D_not_late", send_out3, 4'b0000);
    credit_in3[0] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      check("D_credit_out", credit_out3[0], (k == 3));
      check("D_idle", idle3[0], (k == 4));
      next_cycle();
    end
    check("D_cnt_back", cnt3[0], 3'd4);
    repeat (4) next_cycle();

    // Reset with two flits in flight on lane 0
    drive2(0, 32'h11111111, 6'd1, 1'b0, 1'b0);
    next_cycle();
    drive2(0, 32'h22222222, 6'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    check("E_send_out", send_out2, 4'b0000);
    check("E_cnt2", cnt2, ALL4);
    check("E_cnt0", cnt0, ALL4);
    check("E_flags2", {uf2, of2}, 8'h00);
    check("E_flags0", {uf0, of0}, 8'h00);
    check("E_idle2", idle2, 4'b1111);
    check("E_idle0", idle0, 4'b1111);
    check("E_idle3", idle3, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      check("E_no_ghost", send_out2, 4'b0000);
    end

`ifdef NOC_LINK_STATS_EN
    // Three 4-flit packets on lane 3, then a clear coinciding with a send
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 4; f++) begin
        drive2(3, $urandom, 6'(p), (f == 3), 1'b1);
        next_cycle();
      end
    end
    check("S_flit_count", fc2[3], 32'd12);
    check("S_pkt_count", pc2[3], 32'd3);
    check("S_other_lane", fc2[0], 32'd0);
    stats_clear = 1'b1;
    drive2(3, $urandom, 6'd5, 1'b1, 1'b1);
    next_cycle();
    check("S_clear_flit", fc2[3], 32'd0);
    check("S_clear_pkt", pc2[3], 32'd0);
    check("S_idle_links", {fc0[0], pc3[0]}, 64'd0);
`endif

    repeat (4) next_cycle();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
